// File: rtl/memlcd_frame_scheduler_if.sv
// Bundles the scheduler's command, dirty-flag, framebuffer and SPI byte-stream signals.
// Wiring only; no storage and no added latency.
// tx_valid/tx_ready carry the byte-stream backpressure; the other groups use fixed-latency handshakes.
interface memlcd_frame_scheduler_if #(
    parameter int FB_AW = 15
);
    logic             cmd_update;
    logic             cmd_update_all;
    logic             cmd_clear;
    logic             vcom_tick;
    logic             busy;
    logic             done;
    logic             vcom;
    logic [9:0]       dirty_addr;
    logic             dirty_in;
    logic             dirty_clr;
    logic [FB_AW-1:0] fb_addr;
    logic [7:0]       fb_rdata;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_last;

    // Scheduler side.
    modport master (
        input  cmd_update, cmd_update_all, cmd_clear, vcom_tick,
        input  dirty_in, fb_rdata, tx_ready,
        output busy, done, vcom, dirty_addr, dirty_clr, fb_addr,
        output tx_data, tx_valid, tx_last
    );

    // CSR / RAM / SPI-engine side.
    modport slave (
        output cmd_update, cmd_update_all, cmd_clear, vcom_tick,
        output dirty_in, fb_rdata, tx_ready,
        input  busy, done, vcom, dirty_addr, dirty_clr, fb_addr,
        input  tx_data, tx_valid, tx_last
    );
endinterface

// File: rtl/memlcd_frame_scheduler.sv
// Memory-LCD frame sequencer: scans dirty lines, streams header+data bytes, issues all-clear and VCOM frames.
// Granted frame starts the cycle after arbitration; line data runs at one byte per 2 clk.
// tx_valid/tx_ready: a presented byte is held stable until accepted; the scan stalls while it waits.
module memlcd_frame_scheduler #(
    parameter int LINES      = 536,
    parameter int LINE_BYTES = 42,
    parameter int FB_AW      = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    memlcd_frame_scheduler_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_SCAN, S_HDR0, S_HDR1, S_DATA, S_TRAIL,
        S_CLR0, S_CLR1, S_VC0, S_VC1, S_DONE
    } state_t;

    localparam int               CW        = $clog2(LINE_BYTES + 1);
    localparam logic [9:0]       LAST_LINE = 10'(LINES - 1);
    localparam logic [FB_AW-1:0] LINE_STEP = FB_AW'(LINE_BYTES);
    localparam logic [CW-1:0]    LB_CNT    = CW'(LINE_BYTES);

    state_t           state_q, state_d;
    logic             vcom_q;
    logic             pend_clear_q, pend_all_q, pend_upd_q, pend_vcom_q;
    logic             all_mode_q, sent_any_q, scan_wait_q, rd_vld_q;
    logic [9:0]       line_q;
    logic [FB_AW-1:0] line_base_q, fb_addr_q;
    logic [CW-1:0]    data_cnt_q;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q, tx_last_q;

    logic tx_acc, last_line, line_hit, data_done, data_load;
    logic start_clear, start_scan, start_vc, byte0_acc, line_adv;
    logic enter_hdr, enter_last;
    logic busy_o, done_o, dirty_clr_o;

    assign tx_acc     = tx_valid_q & bus.tx_ready;
    assign last_line  = (line_q == LAST_LINE);
    // dirty_in is only meaningful on the second SCAN cycle of a line
    assign line_hit   = scan_wait_q & (all_mode_q | bus.dirty_in);
    assign data_done  = (state_q == S_DATA) & tx_acc & (data_cnt_q == LB_CNT);
    // fetch the next byte once the RAM output reflects fb_addr_q and the output stage is empty
    assign data_load  = (state_q == S_DATA) & ~tx_valid_q & rd_vld_q & (data_cnt_q != LB_CNT);

    assign start_clear = (state_q == S_IDLE) & (state_d == S_CLR0);
    assign start_scan  = (state_q == S_IDLE) & (state_d == S_SCAN);
    assign start_vc    = (state_q == S_IDLE) & (state_d == S_VC0);
    assign byte0_acc   = tx_acc & ((state_q == S_HDR0) | (state_q == S_CLR0));
    assign enter_hdr   = (state_q == S_SCAN) & (state_d == S_HDR0);
    assign enter_last  = (state_d != state_q) &
                         ((state_d == S_TRAIL) | (state_d == S_CLR1) | (state_d == S_VC1));
    assign line_adv    = ((state_q == S_SCAN) & scan_wait_q & ~line_hit & ~last_line) |
                         (data_done & ~last_line);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: IDLE arbitration (clear > update_all > update > vcom) and frame sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pend_clear_q)                  state_d = S_CLR0;
                else if (pend_all_q | pend_upd_q)  state_d = S_SCAN;
                else if (pend_vcom_q)              state_d = S_VC0;
            end
            S_SCAN: begin
                if (scan_wait_q) begin
                    if (line_hit)       state_d = S_HDR0;
                    else if (last_line) state_d = sent_any_q ? S_TRAIL : S_DONE;
                end
            end
            S_HDR0:  if (tx_acc) state_d = S_HDR1;
            S_HDR1:  if (tx_acc) state_d = S_DATA;
            S_DATA:  if (data_done) state_d = last_line ? S_TRAIL : S_SCAN;
            S_TRAIL: if (tx_acc) state_d = S_DONE;
            S_CLR0:  if (tx_acc) state_d = S_CLR1;
            S_CLR1:  if (tx_acc) state_d = S_DONE;
            S_VC0:   if (tx_acc) state_d = S_VC1;
            S_VC1:   if (tx_acc) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM-decoded outputs.
    always_comb begin
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        dirty_clr_o = (state_q == S_HDR0) & tx_acc;
    end

    // Sticky frame requests and VCOM polarity; a request arriving on its own start cycle survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcom_q       <= 1'b0;
            pend_clear_q <= 1'b0;
            pend_all_q   <= 1'b0;
            pend_upd_q   <= 1'b0;
            pend_vcom_q  <= 1'b0;
        end else begin
            vcom_q       <= vcom_q ^ bus.vcom_tick;
            pend_clear_q <= bus.cmd_clear | (pend_clear_q & ~start_clear);
            pend_all_q   <= bus.cmd_update_all | (pend_all_q & ~start_scan);
            pend_upd_q   <= bus.cmd_update |
                            (pend_upd_q & ~start_scan & ~bus.cmd_update_all);
            pend_vcom_q  <= bus.vcom_tick | (pend_vcom_q & ~byte0_acc & ~start_vc);
        end
    end

    // Line scan pointer with running framebuffer base (adds LINE_BYTES per line, no multiplier).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q      <= '0;
            line_base_q <= '0;
            all_mode_q  <= 1'b0;
            sent_any_q  <= 1'b0;
            scan_wait_q <= 1'b0;
        end else begin
            scan_wait_q <= (state_q == S_SCAN) & ~scan_wait_q;
            if (start_scan) begin
                line_q      <= '0;
                line_base_q <= '0;
                all_mode_q  <= pend_all_q;
                sent_any_q  <= 1'b0;
            end else if (line_adv) begin
                line_q      <= line_q + 10'd1;
                line_base_q <= line_base_q + LINE_STEP;
            end
            if (enter_hdr) sent_any_q <= 1'b1;
        end
    end

    // Framebuffer fetch: rd_vld_q marks that fb_rdata now reflects an unchanged fb_addr_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_addr_q  <= '0;
            rd_vld_q   <= 1'b0;
            data_cnt_q <= '0;
        end else if (enter_hdr) begin
            fb_addr_q  <= line_base_q;
            rd_vld_q   <= 1'b0;
            data_cnt_q <= '0;
        end else if (data_load) begin
            fb_addr_q  <= fb_addr_q + FB_AW'(1);
            rd_vld_q   <= 1'b0;
            data_cnt_q <= data_cnt_q + CW'(1);
        end else begin
            rd_vld_q   <= 1'b1;
        end
    end

    // Output byte stage: loaded only when empty or on acceptance, so it never changes under a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
        end else if (start_clear) begin
            tx_data_q  <= {1'b0, vcom_q, 1'b1, 5'b0};
            tx_valid_q <= 1'b1;
            tx_last_q  <= 1'b0;
        end else if (start_vc) begin
            tx_data_q  <= {1'b0, vcom_q, 6'b0};
            tx_valid_q <= 1'b1;
            tx_last_q  <= 1'b0;
        end else if (enter_hdr) begin
            tx_data_q  <= {1'b1, vcom_q, 4'b0, line_q[9:8]};
            tx_valid_q <= 1'b1;
            tx_last_q  <= 1'b0;
        end else if ((state_q == S_HDR0) & tx_acc) begin
            tx_data_q  <= line_q[7:0];
            tx_valid_q <= 1'b1;
            tx_last_q  <= 1'b0;
        end else if (enter_last) begin
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b1;
            tx_last_q  <= 1'b1;
        end else if (data_load) begin
            tx_data_q  <= bus.fb_rdata;
            tx_valid_q <= 1'b1;
            tx_last_q  <= 1'b0;
        end else if (tx_acc) begin
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
        end
    end

    assign bus.busy       = busy_o;
    assign bus.done       = done_o;
    assign bus.vcom       = vcom_q;
    assign bus.dirty_addr = line_q;
    assign bus.dirty_clr  = dirty_clr_o;
    assign bus.fb_addr    = fb_addr_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_last    = tx_last_q;

endmodule

// File: tb/tb_memlcd_frame_scheduler.sv
// Bench for memlcd_frame_scheduler with an 8-line, 4-byte-per-line panel.
// Expected byte streams come from a line-by-line model of the frame format.
// tx_ready is randomised per cycle at a chosen percentage; stalls are checked for stability.
module tb_memlcd_frame_scheduler;
    localparam int LINES = 8;
    localparam int LB    = 4;
    localparam int AW    = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memlcd_frame_scheduler_if #(.FB_AW(AW)) bus();

    memlcd_frame_scheduler #(.LINES(LINES), .LINE_BYTES(LB), .FB_AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int rdy_pct = 100;

    // Dirty-flag RAM and framebuffer (fb[n] = n), both one-cycle read latency.
    logic       dload = 1'b0;
    logic [7:0] dload_mask = 8'h00;
    logic [7:0] dflag = 8'h00;
    always @(posedge clk) begin
        if (dload) dflag <= dload_mask;
        else if (bus.dirty_clr) dflag[bus.dirty_addr[2:0]] <= 1'b0;
        bus.dirty_in <= dflag[bus.dirty_addr[2:0]];
        bus.fb_rdata <= 8'(bus.fb_addr);
    end

    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Mid-cycle monitor: accepted bytes, dirty clears, done pulses, stall stability.
    logic [8:0] cap_q[$];
    int         clr_q[$];
    int         done_cnt = 0;
    int         stall_bad = 0;
    initial begin
        logic       stalled;
        logic [8:0] held;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled && (!bus.tx_valid || {bus.tx_last, bus.tx_data} != held))
                    stall_bad++;
                if (bus.tx_valid && bus.tx_ready) cap_q.push_back({bus.tx_last, bus.tx_data});
                stalled = bus.tx_valid && !bus.tx_ready;
                held = {bus.tx_last, bus.tx_data};
                if (bus.done) done_cnt++;
                if (bus.dirty_clr) clr_q.push_back(int'(bus.dirty_addr));
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: every selected line is {hdr, line, LB data bytes}; a trailer closes a non-empty frame.
    logic [8:0] exp_q[$];
    int         expclr_q[$];
    task automatic build_update(input bit all, input logic [7:0] mask, input bit v0, input int flip_from);
        int v;
        exp_q.delete();
        expclr_q.delete();
        for (int l = 0; l < LINES; l++) begin
            if (all || mask[l]) begin
                v = (l >= flip_from) ? int'(!v0) : int'(v0);
                exp_q.push_back(9'(32'h80 | (v << 6) | ((l >> 8) & 3)));
                exp_q.push_back(9'(l & 255));
                for (int k = 0; k < LB; k++) exp_q.push_back(9'(l * LB + k));
                expclr_q.push_back(l);
            end
        end
        if (expclr_q.size() > 0) exp_q.push_back(9'h100);
    endtask

    task automatic wait_done(input int target, input string nm);
        int n;
        n = 0;
        while (done_cnt < target && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, " done_reached"}, int'(done_cnt >= target), 1);
    endtask

    // mode: 0 update, 1 update_all, 2 clear+update together, 3 vcom tick
    task automatic run_frame(input string nm, input int mode, input logic [7:0] mask,
                             input int pct, input int exp_done, input int tick_after,
                             output int got_len);
        int cb, lb, db, sb, n;
        @(posedge clk); #1;
        rdy_pct = pct;
        dload_mask = mask;
        dload = 1'b1;
        @(posedge clk); #1;
        dload = 1'b0;
        cb = cap_q.size(); lb = clr_q.size(); db = done_cnt; sb = stall_bad;
        bus.cmd_update     = (mode == 0 || mode == 2);
        bus.cmd_update_all = (mode == 1);
        bus.cmd_clear      = (mode == 2);
        bus.vcom_tick      = (mode == 3);
        @(posedge clk); #1;
        bus.cmd_update = 1'b0; bus.cmd_update_all = 1'b0;
        bus.cmd_clear = 1'b0;  bus.vcom_tick = 1'b0;
        if (tick_after >= 0) begin
            n = 0;
            while (cap_q.size() < cb + tick_after && n < 3000) begin
                @(posedge clk); #1;
                n++;
            end
            chk({nm, " tick_point"}, int'(cap_q.size() >= cb + tick_after), 1);
            bus.vcom_tick = 1'b1;
            @(posedge clk); #1;
            bus.vcom_tick = 1'b0;
        end
        wait_done(db + exp_done, nm);
        repeat (16) @(posedge clk);
        #1;
        got_len = cap_q.size() - cb;
        chk({nm, " len"}, got_len, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            int a;
            a = (cb + i < cap_q.size()) ? int'(cap_q[cb + i]) : -1;
            chk($sformatf("%s byte%0d", nm, i), a, int'(exp_q[i]));
        end
        chk({nm, " clr_count"}, clr_q.size() - lb, expclr_q.size());
        for (int i = 0; i < expclr_q.size(); i++) begin
            int a;
            a = (lb + i < clr_q.size()) ? clr_q[lb + i] : -1;
            chk($sformatf("%s clr%0d", nm, i), a, expclr_q[i]);
        end
        chk({nm, " done_count"}, done_cnt - db, exp_done);
        chk({nm, " busy_after"}, int'(bus.busy), 0);
        chk({nm, " valid_after"}, int'(bus.tx_valid), 0);
        chk({nm, " dirty_left"}, int'(dflag), 0);
        chk({nm, " stall_stable"}, stall_bad - sb, 0);
    endtask

    typedef struct {
        int         mode;
        logic [7:0] mask;
        int         pct;
        int         exp_len;   // -1: length comes from the model only
    } vec_t;
    vec_t vecs[10];

    initial begin
        int got;
        bus.cmd_update = 1'b0; bus.cmd_update_all = 1'b0;
        bus.cmd_clear = 1'b0;  bus.vcom_tick = 1'b0;

        vecs[0] = '{0, 8'h88, 100, 13};
        vecs[1] = '{0, 8'h00, 100, 0};
        vecs[2] = '{0, 8'h88, 30, 13};
        vecs[3] = '{1, 8'h05, 100, 49};
        for (int i = 4; i < 10; i++)
            vecs[i] = '{int'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(20, 100)), -1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", int'(bus.busy), 0);
        chk("rst done", int'(bus.done), 0);
        chk("rst tx_valid", int'(bus.tx_valid), 0);
        chk("rst tx_last", int'(bus.tx_last), 0);
        chk("rst tx_data", int'(bus.tx_data), 0);
        chk("rst vcom", int'(bus.vcom), 0);
        chk("rst dirty_clr", int'(bus.dirty_clr), 0);
        chk("rst fb_addr", int'(bus.fb_addr), 0);
        chk("rst dirty_addr", int'(bus.dirty_addr), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 10; i++) begin
            build_update(vecs[i].mode == 1, vecs[i].mask, 1'b0, 1000);
            run_frame($sformatf("vec%0d", i), vecs[i].mode, vecs[i].mask, vecs[i].pct, 1, -1, got);
            if (vecs[i].exp_len >= 0) chk($sformatf("vec%0d table_len", i), got, vecs[i].exp_len);
        end

        // VCOM tick in IDLE: polarity flips and a two-byte VCOM frame follows.
        exp_q.delete(); expclr_q.delete();
        exp_q.push_back(9'h040); exp_q.push_back(9'h100);
        run_frame("vcom_idle", 3, 8'h00, 100, 1, -1, got);
        chk("vcom_idle polarity", int'(bus.vcom), 1);

        // Clear and update requested together: clear wins, update follows.
        build_update(1'b0, 8'h88, 1'b1, 1000);
        exp_q.push_front(9'h100);
        exp_q.push_front(9'h060);
        run_frame("clear_upd", 2, 8'h88, 100, 2, -1, got);

        // Tick after the first line: second header carries the new polarity, no VCOM frame after.
        build_update(1'b0, 8'h88, 1'b1, 4);
        run_frame("tick_mid", 0, 8'h88, 100, 1, 6, got);
        chk("tick_mid polarity", int'(bus.vcom), 0);

        // Async reset in the middle of line data.
        begin
            int cb, n;
            @(posedge clk); #1;
            rdy_pct = 100;
            cb = cap_q.size();
            bus.cmd_update_all = 1'b1;
            @(posedge clk); #1;
            bus.cmd_update_all = 1'b0;
            n = 0;
            while (cap_q.size() < cb + 3 && n < 3000) begin
                @(posedge clk); #1;
                n++;
            end
            chk("rst_mid reached_data", int'(cap_q.size() >= cb + 3), 1);
            rst_n = 1'b0;
            #1;
            chk("rst_mid tx_valid", int'(bus.tx_valid), 0);
            chk("rst_mid busy", int'(bus.busy), 0);
            chk("rst_mid tx_last", int'(bus.tx_last), 0);
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
        build_update(1'b1, 8'h00, 1'b0, 1000);
        run_frame("after_rst_all", 1, 8'h00, 100, 1, -1, got);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
